// File: rtl/sap2_pkg.sv
// Shared constants and types for the SAP-II instruction-cycle sequencer:
// one-hot T-state codes, opcodes with non-trivial lengths, instruction
// lengths and the sequencer state encoding.
package sap2_pkg;

    localparam int RING_W = 18;

    localparam logic [RING_W-1:0] T01 = 18'h00001;
    localparam logic [RING_W-1:0] T02 = 18'h00002;
    localparam logic [RING_W-1:0] T03 = 18'h00004;
    localparam logic [RING_W-1:0] T04 = 18'h00008;
    localparam logic [RING_W-1:0] T05 = 18'h00010;
    localparam logic [RING_W-1:0] T06 = 18'h00020;
    localparam logic [RING_W-1:0] T07 = 18'h00040;
    localparam logic [RING_W-1:0] T08 = 18'h00080;
    localparam logic [RING_W-1:0] T09 = 18'h00100;
    localparam logic [RING_W-1:0] T10 = 18'h00200;
    localparam logic [RING_W-1:0] T11 = 18'h00400;
    localparam logic [RING_W-1:0] T12 = 18'h00800;
    localparam logic [RING_W-1:0] T13 = 18'h01000;
    localparam logic [RING_W-1:0] T14 = 18'h02000;
    localparam logic [RING_W-1:0] T15 = 18'h04000;
    localparam logic [RING_W-1:0] T16 = 18'h08000;
    localparam logic [RING_W-1:0] T17 = 18'h10000;
    localparam logic [RING_W-1:0] T18 = 18'h20000;

    // Opcodes named individually; register-form ALU/MOV opcodes are listed
    // directly in the decoder.
    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_HLT  = 8'h76;
    localparam logic [7:0] OP_CMA  = 8'h2F;
    localparam logic [7:0] OP_RAL  = 8'h17;
    localparam logic [7:0] OP_RAR  = 8'h1F;
    localparam logic [7:0] OP_ANI  = 8'hE6;
    localparam logic [7:0] OP_ORI  = 8'hF6;
    localparam logic [7:0] OP_XRI  = 8'hEE;
    localparam logic [7:0] OP_JMP  = 8'hC3;
    localparam logic [7:0] OP_IN   = 8'hDB;
    localparam logic [7:0] OP_OUT  = 8'hD3;
    localparam logic [7:0] OP_RET  = 8'hC9;
    localparam logic [7:0] OP_JZ   = 8'hCA;
    localparam logic [7:0] OP_JNZ  = 8'hC2;
    localparam logic [7:0] OP_JM   = 8'hFA;
    localparam logic [7:0] OP_LDA  = 8'h3A;
    localparam logic [7:0] OP_STA  = 8'h32;
    localparam logic [7:0] OP_CALL = 8'hCD;

    // Instruction lengths in T-states.
    localparam logic [4:0] LEN_SHORT = 5'd4;
    localparam logic [4:0] LEN_HLT   = 5'd5;
    localparam logic [4:0] LEN_IMM   = 5'd7;
    localparam logic [4:0] LEN_JMP   = 5'd10;
    localparam logic [4:0] LEN_MEM   = 5'd13;
    localparam logic [4:0] LEN_CALL  = 5'd18;

    typedef enum logic [1:0] {
        ST_START,
        ST_RUN,
        ST_HALT,
        ST_STEP_WAIT
    } seq_state_e;

endpackage

// File: rtl/instr_len_decode.sv
// Combinational opcode -> instruction length decoder. Conditional jumps
// take their long form only when the branch is taken.
module instr_len_decode
    import sap2_pkg::*;
(
    input  logic [7:0] opcode_i,
    input  logic       zf_i,
    input  logic       sf_i,
    output logic [4:0] len_o,
    output logic       is_hlt_o,
    output logic       is_illegal_o
);

    // Length lookup; unknown opcodes run as a 4-state NOP and are flagged.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        len_o        = LEN_SHORT;
        is_hlt_o     = 1'b0;
        is_illegal_o = 1'b0;
        case (opcode_i)
            OP_NOP,
            8'h78, 8'h79, 8'h7A, 8'h47, 8'h4F, 8'h57, 8'h41, 8'h48,
            8'h80, 8'h81, 8'h90, 8'h91, 8'hA0, 8'hA1, 8'hB0, 8'hB1,
            8'hA8, 8'hA9, 8'h3C, 8'h3D, 8'h04, 8'h05, 8'h0C, 8'h0D,
            OP_CMA, OP_RAL, OP_RAR:              len_o = LEN_SHORT;
            OP_HLT: begin
                len_o    = LEN_HLT;
                is_hlt_o = 1'b1;
            end
            8'h3E, 8'h06, 8'h0E,
            OP_ANI, OP_ORI, OP_XRI:              len_o = LEN_IMM;
            OP_JMP, OP_IN, OP_OUT, OP_RET:       len_o = LEN_JMP;
            OP_JZ:                               len_o = zf_i  ? LEN_JMP : LEN_IMM;
            OP_JNZ:                              len_o = !zf_i ? LEN_JMP : LEN_IMM;
            OP_JM:                               len_o = sf_i  ? LEN_JMP : LEN_IMM;
            OP_LDA, OP_STA:                      len_o = LEN_MEM;
            OP_CALL:                             len_o = LEN_CALL;
            default:                             is_illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/tstate_sequencer.sv
// SAP-II instruction-cycle scheduler. Follows the ring counter's one-hot
// T-state, ends each instruction at its true last T-state by pulling the
// ring's clear, and handles HLT, single-step, ring desync and retire count.
module tstate_sequencer
    import sap2_pkg::*;
#(
    parameter int NT    = 18,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [NT-1:0]    tstate,
    input  logic [7:0]       bus_opcode,
    input  logic             zf,
    input  logic             sf,
    input  logic             step_mode,
    input  logic             step,
    input  logic             run,
    output logic             ring_nclr,
    output logic             hold,
    output logic             halted,
    output logic             step_wait,
    output logic             instr_done,
    output logic [4:0]       cur_len,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal,
    output logic [7:0]       illegal_op,
    output logic             sync_err
);

    seq_state_e       state_q, state_d;
    logic             ring_nclr_q, ring_nclr_d;
    logic             hold_q, hold_d;
    logic             halted_q, halted_d;
    logic             step_wait_q, step_wait_d;
    logic             done_q, done_d;
    logic [4:0]       len_q, len_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             illegal_q, illegal_d;
    logic [7:0]       ill_op_q, ill_op_d;
    logic             sync_err_q, sync_err_d;
    logic [4:0]       idx_q, idx_d;        // expected T-state index (0 = T01)
    logic             last_nclr_q;         // ring_nclr value of the previous cycle
    logic             abort_q, abort_d;    // forced-clear cycle after a desync
    logic             hlt_q, hlt_d;        // current instruction is HLT

    logic [4:0]       dec_len;
    logic             dec_hlt;
    logic             dec_ill;
    logic [NT-1:0]    exp_onehot;
    logic             mismatch;
    logic             at_t03;

    instr_len_decode u_decode (
        .opcode_i     (bus_opcode),
        .zf_i         (zf),
        .sf_i         (sf),
        .len_o        (dec_len),
        .is_hlt_o     (dec_hlt),
        .is_illegal_o (dec_ill)
    );

    // Desync detection: skipped right after the ring was cleared and during an abort.
    always_comb begin
        exp_onehot = {{(NT-1){1'b0}}, 1'b1} << idx_q;
        mismatch   = (state_q == ST_RUN) && last_nclr_q && !abort_q && (tstate != exp_onehot);
        at_t03     = (state_q == ST_RUN) && !abort_q && !mismatch && (idx_q == 5'd2);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        ring_nclr_d = ring_nclr_q;
        hold_d      = hold_q;
        halted_d    = halted_q;
        step_wait_d = step_wait_q;
        done_d      = 1'b0;
        len_d       = len_q;
        count_d     = count_q;
        illegal_d   = illegal_q;
        ill_op_d    = ill_op_q;
        sync_err_d  = sync_err_q;
        idx_d       = idx_q;
        abort_d     = 1'b0;
        hlt_d       = hlt_q;

        case (state_q)
            ST_START: begin
                state_d     = ST_RUN;
                ring_nclr_d = 1'b1;
                hold_d      = 1'b0;
                idx_d       = 5'd0;
            end

            ST_RUN: begin
                ring_nclr_d = 1'b1;
                hold_d      = 1'b0;
                idx_d       = idx_q + 5'd1;
                if (abort_q) begin
                    idx_d = 5'd0;
                end else if (mismatch) begin
                    sync_err_d  = 1'b1;
                    ring_nclr_d = 1'b0;
                    abort_d     = 1'b1;
                end else if (done_q) begin
                    // Last T-state of the instruction: retire and pick what follows.
                    count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    idx_d   = 5'd0;
                    if (hlt_q) begin
                        state_d     = ST_HALT;
                        ring_nclr_d = 1'b0;
                        hold_d      = 1'b1;
                        halted_d    = 1'b1;
                    end else if (step_mode) begin
                        state_d     = ST_STEP_WAIT;
                        ring_nclr_d = 1'b0;
                        hold_d      = 1'b1;
                        step_wait_d = 1'b1;
                    end
                end else begin
                    if (at_t03) begin
                        len_d = dec_len;
                        hlt_d = dec_hlt;
                        if (dec_ill) begin
                            illegal_d = 1'b1;
                            if (!illegal_q) ill_op_d = bus_opcode;
                        end
                    end
                    // Clear is registered, so decide one T-state early; 4-state
                    // instructions use the live decode because len_q is still stale.
                    if ((at_t03 && dec_len == LEN_SHORT) ||
                        (idx_q >= 5'd3 && (idx_q + 5'd2) == len_q)) begin
                        ring_nclr_d = 1'b0;
                        done_d      = 1'b1;
                    end
                end
            end

            ST_HALT: begin
                if (run) begin
                    state_d     = ST_RUN;
                    ring_nclr_d = 1'b1;
                    hold_d      = 1'b0;
                    halted_d    = 1'b0;
                    idx_d       = 5'd0;
                end
            end

            ST_STEP_WAIT: begin
                if (step) begin
                    state_d     = ST_RUN;
                    ring_nclr_d = 1'b1;
                    hold_d      = 1'b0;
                    step_wait_d = 1'b0;
                    idx_d       = 5'd0;
                end
            end

            default: state_d = ST_START;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (CLR) begin
            state_q     <= ST_START;
            ring_nclr_q <= 1'b0;
            hold_q      <= 1'b1;
            halted_q    <= 1'b0;
            step_wait_q <= 1'b0;
            done_q      <= 1'b0;
            len_q       <= LEN_SHORT;
            count_q     <= '0;
            illegal_q   <= 1'b0;
            ill_op_q    <= 8'h00;
            sync_err_q  <= 1'b0;
            idx_q       <= 5'd0;
            last_nclr_q <= 1'b0;
            abort_q     <= 1'b0;
            hlt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ring_nclr_q <= ring_nclr_d;
            hold_q      <= hold_d;
            halted_q    <= halted_d;
            step_wait_q <= step_wait_d;
            done_q      <= done_d;
            len_q       <= len_d;
            count_q     <= count_d;
            illegal_q   <= illegal_d;
            ill_op_q    <= ill_op_d;
            sync_err_q  <= sync_err_d;
            idx_q       <= idx_d;
            last_nclr_q <= ring_nclr_q;
            abort_q     <= abort_d;
            hlt_q       <= hlt_d;
        end
    end

    assign ring_nclr   = ring_nclr_q;
    assign hold        = hold_q;
    assign halted      = halted_q;
    assign step_wait   = step_wait_q;
    assign instr_done  = done_q;
    assign cur_len     = len_q;
    assign instr_count = count_q;
    assign illegal     = illegal_q;
    assign illegal_op  = ill_op_q;
    assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tstate_sequencer.sv
// Bench for tstate_sequencer: a ring-counter model drives tstate, a driver
// feeds opcodes at T03 and queues the expected retirement, and a monitor
// compares each instr_done against that queue.
module tb_tstate_sequencer;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic [17:0] tstate;
    logic [7:0]  bus_opcode = 8'h00;
    logic        zf = 1'b0, sf = 1'b0;
    logic        step_mode = 1'b0, step = 1'b0, run = 1'b0;
    logic        ring_nclr, hold, halted, step_wait, instr_done;
    logic [4:0]  cur_len;
    logic [15:0] instr_count;
    logic        illegal;
    logic [7:0]  illegal_op;
    logic        sync_err;

    tstate_sequencer #(.NT(18), .CNT_W(16)) dut (
        .CLK(CLK), .CLR(CLR), .tstate(tstate), .bus_opcode(bus_opcode),
        .zf(zf), .sf(sf), .step_mode(step_mode), .step(step), .run(run),
        .ring_nclr(ring_nclr), .hold(hold), .halted(halted), .step_wait(step_wait),
        .instr_done(instr_done), .cur_len(cur_len), .instr_count(instr_count),
        .illegal(illegal), .illegal_op(illegal_op), .sync_err(sync_err)
    );

    always #5 CLK = ~CLK;

    // Ring counter model, with an override used to inject a desync.
    logic [17:0] ring_q = 18'd1;
    logic        force_en = 1'b0;
    logic [17:0] force_val = 18'd0;
    always @(posedge CLK)
        if (ring_nclr !== 1'b1) ring_q <= 18'd1;
        else                    ring_q <= {ring_q[16:0], ring_q[17]};
    assign tstate = force_en ? force_val : ring_q;

    typedef struct { logic [7:0] op; logic z; logic s; bit abort; } prog_t;
    typedef struct { int len; bit hlt; int cnt; bit ill; logic [7:0] ill_op; } exp_t;

    prog_t prog[$];
    exp_t  exp_q[$];
    int    checks = 0, failures = 0;
    int    ref_count = 0;
    bit    ref_ill = 0;
    logic [7:0] ref_ill_op = 8'h00;
    bit    armed_abort = 0;
    int    last_len = 0;
    bit    pend = 0;
    exp_t  pend_it;
    bit    pend_step = 0;
    int    idle = 0;

    int len_tab[int];
    int legal[$];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", nm, got, exp, $time);
        end
    endtask

    // Instruction length from the opcode table plus branch-taken rules.
    function automatic int ref_len(input logic [7:0] op, input logic z, input logic s, output bit ill);
        ill = 1'b0;
        if (op == 8'hCA) return z ? 10 : 7;
        if (op == 8'hC2) return z ? 7 : 10;
        if (op == 8'hFA) return s ? 10 : 7;
        if (len_tab.exists(int'(op))) return len_tab[int'(op)];
        ill = 1'b1;
        return 4;
    endfunction

    // Driver: present opcode at T03, random noise otherwise; queue expectations.
    always begin
        @(posedge CLK); #1;
        if (CLR === 1'b0 && hold === 1'b0 && tstate == 18'd4) begin
            prog_t p;
            exp_t  e;
            bit    ill;
            int    l;
            if (prog.size() != 0) p = prog.pop_front();
            else                  p = '{op: 8'h00, z: 1'b0, s: 1'b0, abort: 1'b0};
            bus_opcode = p.op; zf = p.z; sf = p.s;
            l = ref_len(p.op, p.z, p.s, ill);
            if (ill && !ref_ill) begin ref_ill = 1'b1; ref_ill_op = p.op; end
            if (p.abort) armed_abort = 1'b1;
            else begin
                e = '{len: l, hlt: (p.op == 8'h76), cnt: ref_count, ill: ref_ill, ill_op: ref_ill_op};
                exp_q.push_back(e);
                ref_count++;
            end
        end else begin
            bus_opcode = 8'($urandom); zf = 1'($urandom); sf = 1'($urandom);
        end
    end

    // Monitor: on every retirement pop the expectation and compare.
    always @(negedge CLK) begin
        if (CLR !== 1'b0) begin
            pend = 0; idle = 0;
        end else begin
            if (pend) begin
                check("count_after", instr_count, 32'((pend_it.cnt + 1) & 'hFFFF));
                check("halted_after", halted, pend_it.hlt);
                check("step_wait_after", step_wait, pend_step);
                pend = 0;
            end
            if (instr_done === 1'b1) begin
                check("done_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_t it;
                    it = exp_q.pop_front();
                    check("cur_len", cur_len, it.len);
                    check("done_tstate", tstate, 32'(18'd1 << (it.len - 1)));
                    check("done_nclr", ring_nclr, 0);
                    check("count_at_done", instr_count, 32'(it.cnt & 'hFFFF));
                    check("illegal", illegal, it.ill);
                    check("illegal_op", illegal_op, it.ill_op);
                    last_len  = it.len;
                    pend_it   = it;
                    pend_step = !it.hlt && step_mode;
                    pend      = 1;
                end
                idle = 0;
            end else if (hold === 1'b0) begin
                idle++;
                if (idle > 40) begin
                    check("watchdog_idle", idle, 40);
                    idle = 0;
                end
            end
        end
    end

    task automatic tick;
        @(posedge CLK); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ring_nclr"}, ring_nclr, 0);
        check({tag, "_hold"}, hold, 1);
        check({tag, "_halted"}, halted, 0);
        check({tag, "_step_wait"}, step_wait, 0);
        check({tag, "_instr_done"}, instr_done, 0);
        check({tag, "_cur_len"}, cur_len, 4);
        check({tag, "_instr_count"}, instr_count, 0);
        check({tag, "_illegal"}, illegal, 0);
        check({tag, "_illegal_op"}, illegal_op, 0);
        check({tag, "_sync_err"}, sync_err, 0);
    endtask

    // Assert CLR for n edges, flush bench state, then verify START -> RUN at T01.
    task automatic do_clr(input string tag, input int n);
        tick; CLR = 1'b1;
        @(negedge CLK); @(negedge CLK);
        prog.delete(); exp_q.delete();
        ref_count = 0; ref_ill = 0; ref_ill_op = 8'h00; armed_abort = 0;
        check_reset_vals(tag);
        repeat (n - 1) tick;
        CLR = 1'b0;
        @(negedge CLK);
        check({tag, "_start_hold"}, hold, 1);
        check({tag, "_start_nclr"}, ring_nclr, 0);
        @(negedge CLK);
        check({tag, "_run_hold"}, hold, 0);
        check({tag, "_run_nclr"}, ring_nclr, 1);
        check({tag, "_run_t01"}, tstate, 1);
    endtask

    // sel: 0 = halted, 1 = step_wait, 2 = program and scoreboard drained.
    task automatic wait_for(input string nm, input int sel, input int max_cyc);
        bit ok = 0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge CLK);
            case (sel)
                0:       ok = (halted === 1'b1);
                1:       ok = (step_wait === 1'b1);
                default: ok = (prog.size() == 0 && exp_q.size() == 0 && !pend);
            endcase
        end
        check(nm, ok, 1);
    endtask

    task automatic pulse_step;
        tick; step = 1'b1; tick; step = 1'b0;
    endtask

    task automatic pulse_run;
        tick; run = 1'b1; tick; run = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        int ops4[$]  = '{'h00, 'h78, 'h79, 'h7A, 'h47, 'h4F, 'h57, 'h41, 'h48, 'h80, 'h81,
                         'h90, 'h91, 'hA0, 'hA1, 'hB0, 'hB1, 'hA8, 'hA9, 'h3C, 'h3D,
                         'h04, 'h05, 'h0C, 'h0D, 'h2F, 'h17, 'h1F};
        int ops7[$]  = '{'h3E, 'h06, 'h0E, 'hE6, 'hF6, 'hEE};
        int ops10[$] = '{'hC3, 'hDB, 'hD3, 'hC9};
        int good;
        bit hit;
        foreach (ops4[i])  len_tab[ops4[i]]  = 4;
        foreach (ops7[i])  len_tab[ops7[i]]  = 7;
        foreach (ops10[i]) len_tab[ops10[i]] = 10;
        len_tab['h76] = 5; len_tab['h3A] = 13; len_tab['h32] = 13; len_tab['hCD] = 18;
        foreach (len_tab[k]) if (k != 'h76) legal.push_back(k);
        legal.push_back('hCA); legal.push_back('hC2); legal.push_back('hFA);

        // Reset, NOP stream, conditional jumps both ways, CALL.
        prog.push_back('{8'h00, 1'b0, 1'b0, 1'b0});
        prog.push_back('{8'h00, 1'b0, 1'b0, 1'b0});
        prog.push_back('{8'h00, 1'b0, 1'b0, 1'b0});
        do_clr("rst", 2);
        prog.push_back('{8'hCA, 1'b1, 1'b0, 1'b0});
        prog.push_back('{8'hCA, 1'b0, 1'b0, 1'b0});
        prog.push_back('{8'hCD, 1'b0, 1'b0, 1'b0});
        wait_for("drain_basic", 2, 400);
        check("call_len", last_len, 18);

        // HLT: parked at T01, step ignored, run releases into fetch.
        tick; prog.push_back('{8'h76, 1'b0, 1'b0, 1'b0});
        wait_for("halt_entry", 0, 100);
        good = 0;
        for (int i = 0; i < 20; i++) begin
            tick; step = (i == 8);
            @(negedge CLK);
            if (tstate == 18'd1 && ring_nclr === 1'b0 && hold === 1'b1 && halted === 1'b1) good++;
        end
        step = 1'b0;
        check("halt_parked_cycles", good, 20);
        prog.push_back('{8'h06, 1'b0, 1'b0, 1'b0});
        pulse_run;
        @(negedge CLK);
        check("run_rel_hold", hold, 0);
        check("run_rel_nclr", ring_nclr, 1);
        check("run_rel_halted", halted, 0);
        check("run_rel_t01", tstate, 1);
        wait_for("drain_after_run", 2, 100);
        check("post_halt_len", last_len, 7);

        // Single-step: LDA then MVI each stop in STEP_WAIT; run is ignored there.
        tick; step_mode = 1'b1;
        wait_for("step_entry", 1, 100);
        prog.push_back('{8'h3A, 1'b0, 1'b0, 1'b0});
        prog.push_back('{8'h3E, 1'b0, 1'b0, 1'b0});
        pulse_step;
        @(negedge CLK);
        check("step_rel_wait", step_wait, 0);
        check("step_rel_t01", tstate, 1);
        wait_for("step_lda", 1, 100);
        check("step_lda_len", last_len, 13);
        pulse_run;
        @(negedge CLK);
        check("run_in_step_ignored", step_wait, 1);
        pulse_step;
        wait_for("step_mvi", 1, 100);
        check("step_mvi_len", last_len, 7);
        tick; step_mode = 1'b0;
        pulse_step;

        // Randomized opcode stream, including unknown opcodes.
        for (int i = 0; i < 40; i++) begin
            logic [7:0] op;
            if ($urandom_range(0, 9) < 8) op = 8'(legal[$urandom_range(0, legal.size() - 1)]);
            else begin
                op = 8'($urandom);
                if (op == 8'h76) op = 8'hFF;
            end
            prog.push_back('{op, 1'($urandom), 1'($urandom), 1'b0});
        end
        wait_for("drain_random", 2, 2000);

        // Unknown opcode, injected desync, then CLR mid-instruction.
        do_clr("clr2", 2);
        prog.push_back('{8'hFF, 1'b0, 1'b0, 1'b0});
        prog.push_back('{8'h3E, 1'b0, 1'b0, 1'b1});
        hit = 0;
        for (int i = 0; i < 100 && !hit; i++) begin
            tick;
            hit = armed_abort && (tstate == 18'h00010);
        end
        check("abort_reached_t05", hit, 1);
        force_val = 18'h00100; force_en = 1'b1;
        tick; force_en = 1'b0;
        @(negedge CLK);
        check("sync_err_set", sync_err, 1);
        check("sync_nclr_low", ring_nclr, 0);
        check("sync_no_done", instr_done, 0);
        check("sync_no_count", instr_count, 1);
        check("ill_sticky", illegal, 1);
        check("ill_op_ff", illegal_op, 8'hFF);
        @(negedge CLK);
        check("sync_restart_nclr", ring_nclr, 1);
        check("sync_restart_t01", tstate, 1);
        check("sync_restart_count", instr_count, 1);
        repeat (6) tick;
        do_clr("clr_mid", 2);
        prog.push_back('{8'h00, 1'b0, 1'b0, 1'b0});
        wait_for("drain_final", 2, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tstate_sequencer.md
Name: tstate_sequencer

Overview:
Instruction-cycle scheduler for the SAP-II control path. It watches the 18-bit one-hot T-state from the ring counter and decides each instruction's length from the opcode and flags. It drives the ring counter's active-low clear to end every instruction at its true last T-state. It also handles HLT, single-step mode, ring-counter desynchronisation and retired-instruction counting.

Parameters:
NT, 18, number of T-states (ring width)
CNT_W, 16, instr_count width

Ports:
CLK  in  1  clock
CLR  in  1  reset, synchronous, active-high
tstate  in  NT  one-hot T-state from ring counter (bit0 = T01)
bus_opcode  in  8  W-bus value; holds the opcode during T03
zf  in  1  zero flag
sf  in  1  sign flag
step_mode  in  1  1 = pause after every instruction
step  in  1  one-cycle pulse: release a step pause
run  in  1  one-cycle pulse: leave HALT
ring_nclr  out  1  to ring counter nCLR (0 = next state T01)
hold  out  1  1 = control unit must emit an all-inactive control word
halted  out  1  in HALT
step_wait  out  1  in STEP_WAIT
instr_done  out  1  high during the last T-state of a retired instruction
cur_len  out  5  length in T-states of the current instruction
instr_count  out  CNT_W  retired-instruction count
illegal  out  1  sticky: unknown opcode seen
illegal_op  out  8  first unknown opcode
sync_err  out  1  sticky: T-state mismatch seen

Behaviour:
- Interface: one clock CLK; reset CLR is synchronous and active-high.
- All outputs are registered.
- Reset values: ring_nclr=0, hold=1, halted=0, step_wait=0, instr_done=0, cur_len=4, instr_count=0, illegal=0, illegal_op=0, sync_err=0, state=START.
- FSM states: START, RUN, HALT, STEP_WAIT.
  - START lasts 1 cycle, then RUN with ring_nclr=1 and hold=0.
  - Because ring_nclr was 0 during START, ring is at T01 on the first RUN cycle.
- Length decode at T03, using bus_opcode, zf and sf sampled that cycle:
  - NOP 00, MOV 78/79/7A/47/4F/57/41/48, ADD 80/81, SUB 90/91, ANA A0/A1, ORA B0/B1, XRA A8/A9, INR/DCR 3C/3D/04/05/0C/0D, CMA 2F, RAL 17, RAR 1F: 4
  - HLT 76: 5
  - MVI 3E/06/0E, ANI E6, ORI F6, XRI EE: 7
  - JMP C3, IN DB, OUT D3, RET C9: 10
  - JZ CA: 10 if zf else 7
  - JNZ C2: 10 if !zf else 7
  - JM FA: 10 if sf else 7
  - LDA 3A, STA 32: 13
  - CALL CD: 18
  - Any other opcode: length 4 (executed as NOP); set illegal; capture illegal_op only if illegal was 0.
- cur_len is loaded at the T03 edge. During T01–T03 it reads 4 (or the previous value until loaded).
- End of instruction (len L):
  - ring_nclr=0 and instr_done=1 exactly during the cycle tstate==T(L). Both are registered from tstate==T(L-1).
  - For L=4 the decision uses the live decode at T03.
  - instr_count increments at the T(L) edge and wraps at all-ones.
- After T(L) of a HLT: go to HALT. ring_nclr stays 0 (ring parked at T01), hold=1, halted=1.
- After T(L) of any other instruction with step_mode=1: go to STEP_WAIT with the same outputs, but step_wait=1 instead of halted.
- Release from HALT or STEP_WAIT:
  - HALT is released by run; STEP_WAIT is released by step.
  - The next cycle has ring_nclr=1 and hold=0; the ring is at T01 that cycle and fetch proceeds.
  - run in STEP_WAIT and step in HALT are ignored.
  - If step_mode=1 after a run release, one instruction executes, then STEP_WAIT.
- Sync check: an internal index tracks the expected T-state in RUN.
  - If tstate is not one-hot or differs from the expected index: set sync_err, abort the instruction (no count, no instr_done), force ring_nclr=0 for one cycle, then restart at T01.
  - Checks are suppressed while ring_nclr=0 was applied in the previous cycle.
- CLR mid-instruction aborts immediately and applies the reset values. Stickies clear only on CLR.

Decomposition:
- sap2_pkg: T01..T18 one-hot constants, opcode constants, length constants, FSM state enum.
- Sub-module instr_len_decode: combinational (opcode, zf, sf) -> (len[4:0], is_hlt, is_illegal).

Test Plan:
- CLR 2 cycles, then NOP stream -> ring_nclr low in T04 of each instruction; instr_done pulses every 4 cycles; instr_count 1,2,3.
- JZ with zf=1, then JZ with zf=0 -> cur_len 10 then 7; ring_nclr low at T10, then at T07.
- CALL CD -> full 18 T-states, no early clear; instr_count +1 at T18.
- HLT 76 -> halted=1 after T05; ring held at T01 for 20 cycles; step ignored; run pulse -> next cycle hold=0, fetch of the next opcode.
- step_mode=1 with LDA then MVI -> step_wait after T13; step pulse -> MVI runs 7 T-states, then step_wait again.
- Opcode FF, then tstate forced to T09 during T05, then CLR mid-instruction -> illegal=1 and illegal_op=FF; sync_err=1, no count, ring_nclr=0 for 1 cycle; CLR clears all stickies and instr_count=0.
